// File: rtl/pc_branch_unit.sv
// pc_branch_unit: registered PC with stall, decode-stage branch resolution with flush, sticky halt.
// Optional saturating branch statistics counters are compiled in with `define PC_BR_STATS_EN.
module pc_branch_unit #(
   parameter int ADDR_W   = 16,
   parameter int OFF_W    = 9,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              halt_in,
   input  logic              br_valid,
   input  logic              br_reg,
   input  logic [2:0]        br_cond,
   input  logic [2:0]        flags,
   input  logic [OFF_W-1:0]  br_imm,
   input  logic [ADDR_W-1:0] br_rs,
   input  logic [ADDR_W-1:0] br_pc_plus2,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus2,
   output logic              taken,
   output logic              flush,
   output logic              halted,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  tkn_cnt
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_imm_sext;
   logic [ADDR_W-1:0] w_imm_off;
   logic [ADDR_W-1:0] w_target;
   logic              w_resolve;
   logic              w_cond_true;
   logic              w_taken;

   wire w_z = flags[2];
   wire w_v = flags[1];
   wire w_n = flags[0];

   assign w_resolve = br_valid & ~stall & (r_state == S_RUN);

   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      w_cond_true = 1'b0;
      case (br_cond)
         3'b000:  w_cond_true = ~w_z;
         3'b001:  w_cond_true = w_z;
         3'b010:  w_cond_true = ~w_z & ~w_n;
         3'b011:  w_cond_true = w_n;
         3'b100:  w_cond_true = w_z | (~w_z & ~w_n);
         3'b101:  w_cond_true = w_z | w_n;
         3'b110:  w_cond_true = w_v;
         default: w_cond_true = 1'b1;
      endcase
   end

   // Halfword offset: sign-extend, scale by two; the ADDR_W-wide add wraps by construction.
   assign w_imm_sext = {{(ADDR_W-OFF_W){br_imm[OFF_W-1]}}, br_imm};
   assign w_imm_off  = w_imm_sext << 1;
   assign w_target   = br_reg ? br_rs : (br_pc_plus2 + w_imm_off);
   assign w_taken    = w_resolve & w_cond_true;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
         r_pc    <= LP_RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // A taken branch outranks HLT: the halt sits on the squashed wrong path.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (r_state == S_RUN) begin
         if (w_taken) begin
            w_pc_nxt = w_target;
         end else if (!stall) begin
            if (halt_in) w_state_nxt = S_HALT;
            else         w_pc_nxt    = r_pc + ADDR_W'(2);
         end
      end
   end

   always_comb begin
      taken    = w_taken;
      flush    = w_taken;
      halted   = (r_state == S_HALT);
      pc       = r_pc;
      pc_plus2 = r_pc + ADDR_W'(2);
   end

`ifdef PC_BR_STATS_EN
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_tkn_cnt;

   // Resolve and taken are already masked in HALT, so the counters freeze there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_cnt  <= '0;
         r_tkn_cnt <= '0;
      end else begin
         if (w_resolve && (r_br_cnt != '1))  r_br_cnt  <= r_br_cnt + CNT_W'(1);
         if (w_taken && (r_tkn_cnt != '1))   r_tkn_cnt <= r_tkn_cnt + CNT_W'(1);
      end
   end

   assign br_cnt  = r_br_cnt;
   assign tkn_cnt = r_tkn_cnt;
`else
   assign br_cnt  = '0;
   assign tkn_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: table vectors, directed corner sequences, random vs reference model.
module tb_pc_branch_unit;

   localparam int AW  = 16;
   localparam int OW  = 9;
   localparam int CW  = 2;
   localparam int SAT = (1 << CW) - 1;
`ifdef PC_BR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          halt_in = 1'b0;
   logic          br_valid = 1'b0;
   logic          br_reg = 1'b0;
   logic [2:0]    br_cond = 3'b000;
   logic [2:0]    flags = 3'b000;
   logic [OW-1:0] br_imm = '0;
   logic [AW-1:0] br_rs = '0;
   logic [AW-1:0] br_pc_plus2 = '0;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus2;
   logic          taken;
   logic          flush;
   logic          halted;
   logic [CW-1:0] br_cnt;
   logic [CW-1:0] tkn_cnt;

   pc_branch_unit #(.ADDR_W(AW), .OFF_W(OW), .RESET_PC(0), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .halt_in(halt_in), .br_valid(br_valid),
      .br_reg(br_reg), .br_cond(br_cond), .flags(flags), .br_imm(br_imm), .br_rs(br_rs),
      .br_pc_plus2(br_pc_plus2), .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .flush(flush),
      .halted(halted), .br_cnt(br_cnt), .tkn_cnt(tkn_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [AW-1:0] m_pc;
   bit            m_halt;
   int            m_br;
   int            m_tk;

   typedef struct {
      logic          br_reg;
      logic [2:0]    cond;
      logic [2:0]    flags;
      logic [OW-1:0] imm;
      logic [AW-1:0] rs;
      logic [AW-1:0] pc2;
      logic          exp_taken;
      logic [AW-1:0] exp_target;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
      bit z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic clear_inputs();
      stall = 0; halt_in = 0; br_valid = 0; br_reg = 0; br_cond = 0;
      flags = 0; br_imm = '0; br_rs = '0; br_pc_plus2 = '0;
   endtask

   // One clock: check combinational outputs before the edge, advance the model, check registered state.
   task automatic step();
      bit            e_res, e_tk;
      logic [AW-1:0] tgt;
      #1;
      e_res = br_valid && !stall && !m_halt;
      e_tk  = e_res && cond_ok(br_cond, flags);
      check("taken", taken, e_tk);
      check("flush", flush, e_tk);
      tgt = br_reg ? br_rs : AW'(int'(br_pc_plus2) + 2 * int'($signed(br_imm)));
      @(posedge clk);
      #1;
      if (!m_halt) begin
         if (e_tk)            m_pc = tgt;
         else if (!stall) begin
            if (halt_in)      m_halt = 1'b1;
            else              m_pc = m_pc + AW'(2);
         end
      end
      if (e_res && m_br < SAT) m_br++;
      if (e_tk && m_tk < SAT)  m_tk++;
      check("pc", pc, m_pc);
      check("pc_plus2", pc_plus2, AW'(m_pc + AW'(2)));
      check("halted", halted, m_halt);
      check("br_cnt", br_cnt, STATS ? m_br : 0);
      check("tkn_cnt", tkn_cnt, STATS ? m_tk : 0);
   endtask

   // Asserts reset mid-cycle and checks the asynchronous effect before any clock edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_pc", pc, 16'h0000);
      check("rst_pc_plus2", pc_plus2, 16'h0002);
      check("rst_halted", halted, 0);
      check("rst_br_cnt", br_cnt, 0);
      check("rst_tkn_cnt", tkn_cnt, 0);
      clear_inputs();
      #1;
      check("rst_taken", taken, 0);
      check("rst_flush", flush, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = 16'h0000; m_halt = 0; m_br = 0; m_tk = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // br_reg, cond, flags{Z,V,N}, imm, rs, pc_plus2, taken, target
      vecs[0]  = '{1'b0, 3'd1, 3'b100, 9'h1FE, 16'h0000, 16'h0010, 1'b1, 16'h000C};
      vecs[1]  = '{1'b0, 3'd1, 3'b000, 9'h1FE, 16'h0000, 16'h0010, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 3'd0, 3'b000, 9'h010, 16'h0000, 16'h0100, 1'b1, 16'h0120};
      vecs[3]  = '{1'b0, 3'd0, 3'b100, 9'h010, 16'h0000, 16'h0100, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 3'd2, 3'b000, 9'h0FF, 16'h0000, 16'h0200, 1'b1, 16'h03FE};
      vecs[5]  = '{1'b0, 3'd2, 3'b001, 9'h0FF, 16'h0000, 16'h0200, 1'b0, 16'h0000};
      vecs[6]  = '{1'b0, 3'd3, 3'b001, 9'h100, 16'h0000, 16'h1000, 1'b1, 16'h0E00};
      vecs[7]  = '{1'b0, 3'd3, 3'b100, 9'h100, 16'h0000, 16'h1000, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 3'd4, 3'b100, 9'h000, 16'h4000, 16'h0000, 1'b1, 16'h4000};
      vecs[9]  = '{1'b1, 3'd4, 3'b001, 9'h000, 16'h4000, 16'h0000, 1'b0, 16'h0000};
      vecs[10] = '{1'b1, 3'd4, 3'b101, 9'h000, 16'h5000, 16'h0000, 1'b1, 16'h5000};
      vecs[11] = '{1'b0, 3'd5, 3'b001, 9'h002, 16'h0000, 16'hFFFE, 1'b1, 16'h0002};
      vecs[12] = '{1'b0, 3'd5, 3'b000, 9'h002, 16'h0000, 16'hFFFE, 1'b0, 16'h0000};
      vecs[13] = '{1'b0, 3'd5, 3'b110, 9'h004, 16'h0000, 16'h0300, 1'b1, 16'h0308};
      vecs[14] = '{1'b0, 3'd6, 3'b010, 9'h1FF, 16'h0000, 16'h0000, 1'b1, 16'hFFFE};
      vecs[15] = '{1'b0, 3'd6, 3'b101, 9'h1FF, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[16] = '{1'b1, 3'd7, 3'b000, 9'h000, 16'h1234, 16'h0000, 1'b1, 16'h1234};

      // Reset and free-running fetch
      @(posedge clk);
      do_reset();
      check("free_pc0", pc, 16'h0000);
      step(); check("free_pc1", pc, 16'h0002);
      step(); check("free_pc2", pc, 16'h0004);
      step(); check("free_pc3", pc, 16'h0006);
      do_reset();

      // Condition/target table; vec 15 follows a branch to 0xFFFE so it also covers sequential wrap
      for (int i = 0; i < 17; i++) begin
         logic [AW-1:0] prev_pc;
         prev_pc     = m_pc;
         br_valid    = 1'b1;
         br_reg      = vecs[i].br_reg;
         br_cond     = vecs[i].cond;
         flags       = vecs[i].flags;
         br_imm      = vecs[i].imm;
         br_rs       = vecs[i].rs;
         br_pc_plus2 = vecs[i].pc2;
         #1;
         check($sformatf("tbl%0d_taken", i), taken, vecs[i].exp_taken);
         step();
         check($sformatf("tbl%0d_pc", i), pc,
               vecs[i].exp_taken ? vecs[i].exp_target : AW'(prev_pc + AW'(2)));
      end
      clear_inputs();

      // BR always under stall, then released
      br_valid = 1; br_reg = 1; br_cond = 3'd7; br_rs = 16'h4000; stall = 1;
      step(); step();
      stall = 0;
      step();
      check("br_stall_release_pc", pc, 16'h4000);
      clear_inputs();

      // Stall together with HLT: stay in RUN, PC held
      stall = 1; halt_in = 1;
      step();
      check("stall_halt_halted", halted, 0);
      check("stall_halt_pc", pc, 16'h4000);
      clear_inputs();

      // HLT together with a taken GT branch: branch wins
      br_valid = 1; br_cond = 3'd2; flags = 3'b000; br_pc_plus2 = 16'h0020; br_imm = 9'h008; halt_in = 1;
      step();
      check("br_halt_pc", pc, 16'h0030);
      check("br_halt_halted", halted, 0);
      clear_inputs();
      step();

      // HLT alone: sticky halt, PC frozen despite branches
      do_reset();
      halt_in = 1;
      step();
      check("halt_rise", halted, 1);
      halt_in = 0; br_valid = 1; br_reg = 1; br_cond = 3'd7; br_rs = 16'h2222;
      for (int i = 0; i < 5; i++) step();
      check("halt_frozen_pc", pc, 16'h0000);
      check("halt_still", halted, 1);

      // Counter saturation with five always-taken resolves
      do_reset();
      br_valid = 1; br_reg = 1; br_cond = 3'd7;
      for (int i = 0; i < 5; i++) begin
         br_rs = AW'(16'h0100 * (i + 1));
         step();
      end
      check("sat_br_cnt", br_cnt, STATS ? 3 : 0);
      check("sat_tkn_cnt", tkn_cnt, STATS ? 3 : 0);
      clear_inputs();

      // Mid-run asynchronous reset
      step(); step();
      do_reset();

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
            do_reset();
         end
         stall       = ($urandom_range(0, 3) == 0);
         halt_in     = ($urandom_range(0, 40) == 0);
         br_valid    = 1'($urandom_range(0, 1));
         br_reg      = 1'($urandom_range(0, 1));
         br_cond     = 3'($urandom);
         flags       = 3'($urandom);
         br_imm      = OW'($urandom);
         br_rs       = AW'($urandom);
         br_pc_plus2 = AW'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
